// File: rtl/reg_files.sv
`timescale 1ns/10ps
// Two-read, one-write register file with combinational reads and register 0 tied to zero.
// The asynchronous active-low reset clears every register immediately.
module reg_files #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a same-address write becomes visible only after the edge.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: tb/tb_reg_files.sv
`timescale 1ns/10ps
// Bench for reg_files: reference array model with a scoreboard queue of expected read values.
module tb_reg_files;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;

  logic [DW-1:0] mdl [N];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] e;
  int checks = 0;
  int errors = 0;

  reg_files #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .raddr1(raddr1), .raddr2(raddr2),
    .waddr(waddr), .wdata(wdata), .rdata1(rdata1), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < N; i++) mdl[i] = '0;
  endtask

  // Drives one write across a rising edge and mirrors it into the model.
  task automatic do_write(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we = w; waddr = a; wdata = d;
    @(posedge clk);
    if (w && rst && a != '0) mdl[a] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #5;
    for (int i = 0; i < N; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(N - 1 - i);
      exp_q.push_back('0); exp_q.push_back('0);
      #0.1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin errors++; $display("FAIL reset_rd1[%0d]: got %h want %h", i, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin errors++; $display("FAIL reset_rd2[%0d]: got %h want %h", N-1-i, rdata2, e); end
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < N; a++) do_write(1'b1, AW'(a), DW'(a));
    for (int k = 0; k < N; k++) begin
      raddr1 = AW'(k); raddr2 = AW'(N - 1 - k);
      exp_q.push_back((k == 0) ? '0 : DW'(k));
      exp_q.push_back((k == N - 1) ? '0 : DW'(N - 1 - k));
      #1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin errors++; $display("FAIL fill_rd1[%0d]: got %h want %h", k, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin errors++; $display("FAIL fill_rd2[%0d]: got %h want %h", N-1-k, rdata2, e); end
    end
  endtask

  task automatic test_write_disable();
    do_write(1'b0, AW'(5), 32'hDEADBEEF);
    raddr1 = AW'(5);
    exp_q.push_back(32'd5);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL we0_hold: got %h want %h", rdata1, e); end
  endtask

  task automatic test_reg0();
    do_write(1'b1, '0, 32'hFFFFFFFF);
    raddr1 = '0; raddr2 = '0;
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL reg0_rd1: got %h want %h", rdata1, e); end
    e = exp_q.pop_front(); checks++;
    if (rdata2 !== e) begin errors++; $display("FAIL reg0_rd2: got %h want %h", rdata2, e); end
  endtask

  task automatic test_rdw();
    @(negedge clk);
    raddr1 = AW'(7); waddr = AW'(7); wdata = 32'h12345678; we = 1'b1;
    exp_q.push_back(32'd7);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL rdw_before: got %h want %h", rdata1, e); end
    exp_q.push_back(32'h12345678);
    @(posedge clk);
    mdl[7] = 32'h12345678;
    #1;
    we = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL rdw_after: got %h want %h", rdata1, e); end
  endtask

  task automatic test_mid_reset();
    for (int a = 1; a < N; a++) do_write(1'b1, AW'(a), DW'(32'hA5000000 + a));
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < N; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(N - 1 - i);
      exp_q.push_back(mdl[i]); exp_q.push_back(mdl[N - 1 - i]);
      #0.1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin errors++; $display("FAIL midrst_rd1[%0d]: got %h want %h", i, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin errors++; $display("FAIL midrst_rd2[%0d]: got %h want %h", N-1-i, rdata2, e); end
    end
    // A write attempted while reset is held must be dropped.
    do_write(1'b1, AW'(3), 32'h000000AA);
    raddr1 = AW'(3);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL write_in_reset: got %h want %h", rdata1, e); end
    @(negedge clk);
    rst = 1'b1;
    do_write(1'b1, AW'(3), 32'h000000BB);
    exp_q.push_back(32'h000000BB);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rdata1 !== e) begin errors++; $display("FAIL first_write_after_reset: got %h want %h", rdata1, e); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 3) != 0);
      waddr = AW'($urandom); wdata = $urandom;
      raddr1 = AW'($urandom); raddr2 = (n % 4 == 0) ? raddr1 : AW'($urandom);
      exp_q.push_back(mdl[raddr1]); exp_q.push_back(mdl[raddr2]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin errors++; $display("FAIL b2b_rd1[%0d] addr %0d: got %h want %h", n, raddr1, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin errors++; $display("FAIL b2b_rd2[%0d] addr %0d: got %h want %h", n, raddr2, rdata2, e); end
      @(posedge clk);
      if (we && waddr != '0) mdl[waddr] = wdata;
    end
    @(negedge clk);
    we = 1'b0;
    for (int k = 0; k < N; k++) begin
      raddr1 = AW'(k); raddr2 = AW'(N - 1 - k);
      exp_q.push_back(mdl[k]); exp_q.push_back(mdl[N - 1 - k]);
      #0.1;
      e = exp_q.pop_front(); checks++;
      if (rdata1 !== e) begin errors++; $display("FAIL b2b_final_rd1[%0d]: got %h want %h", k, rdata1, e); end
      e = exp_q.pop_front(); checks++;
      if (rdata2 !== e) begin errors++; $display("FAIL b2b_final_rd2[%0d]: got %h want %h", N-1-k, rdata2, e); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_write_disable();
    test_reg0();
    test_rdw();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
